// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction fetch stage. Issues one outstanding request at a
//               time on a handshaked instruction-memory port, buffers returned
//               words with their PC in a small FIFO and presents the head to
//               the decoder under valid/ready. Redirects flush the queue and
//               discard any response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         imem_req_o,
    output logic [31:0]                  imem_addr_o,
    input  logic                         imem_gnt_i,
    input  logic                         imem_rvalid_i,
    input  logic [31:0]                  imem_rdata_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    output logic                         instr_valid_o,
    output logic [31:0]                  instr_o,
    output logic [31:0]                  pc_o,
    output logic [31:0]                  pc_plus4_o,
    input  logic                         instr_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]          r_state;
    logic [31:0]         r_fpc;
    logic [31:0]         r_inflight_pc;
    logic                r_discard;
    logic [c_ptr_w-1:0]  r_wptr;
    logic [c_ptr_w-1:0]  r_rptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [31:0]         r_fifo_instr [DEPTH];
    logic [31:0]         r_fifo_pc    [DEPTH];

    logic                w_req;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic                w_head_valid;

    // A request is only raised while a free slot exists, so the response
    // accepted in WAIT can always be stored.
    assign w_req        = (r_state == c_st_req) && (r_count < c_depth);
    assign w_grant      = w_req && imem_gnt_i;
    assign w_head_valid = (r_count != '0);
    // A redirect in the same cycle kills both the arriving word and the pop.
    assign w_push       = (r_state == c_st_wait) && imem_rvalid_i && !r_discard && !redirect_i;
    assign w_pop        = w_head_valid && instr_ready_i && !redirect_i;

    // Fetch sequencing: PC generation, single outstanding request, discard of stale responses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= c_st_idle;
            r_fpc         <= RESET_PC;
            r_inflight_pc <= '0;
            r_discard     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_req;
                    if (redirect_i) begin
                        r_fpc <= redirect_pc_i;
                    end
                end
                c_st_req: begin
                    if (w_grant) begin
                        r_state       <= c_st_wait;
                        r_inflight_pc <= r_fpc;
                        r_fpc         <= redirect_i ? redirect_pc_i : (r_fpc + 32'd4);
                        r_discard     <= redirect_i;
                    end else if (redirect_i) begin
                        r_fpc <= redirect_pc_i;
                    end
                end
                c_st_wait: begin
                    if (redirect_i) begin
                        r_fpc <= redirect_pc_i;
                    end
                    if (imem_rvalid_i) begin
                        r_discard <= 1'b0;
                        r_state   <= c_st_req;
                    end else if (redirect_i) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Queue bookkeeping: pointers and occupancy, flushed on redirect
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: write the returned word together with the PC it was fetched from
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_instr[r_wptr] <= imem_rdata_i;
            r_fifo_pc[r_wptr]    <= r_inflight_pc;
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fpc;
    assign instr_valid_o = w_head_valid;
    assign instr_o       = w_head_valid ? r_fifo_instr[r_rptr] : 32'h0;
    assign pc_o          = w_head_valid ? r_fifo_pc[r_rptr]    : 32'h0;
    assign pc_plus4_o    = pc_o + 32'd4;
    assign count_o       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit. A bench-side memory
//               answers requests with addr ^ key; a queue of expected entries
//               plus an expected fetch address form the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [31:0]   imem_rdata_i = 32'h0;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_pc_i = 32'h0;
    logic          instr_valid_o;
    logic [31:0]   instr_o;
    logic [31:0]   pc_o;
    logic [31:0]   pc_plus4_o;
    logic          instr_ready_i = 1'b0;
    logic [CW-1:0] count_o;

    fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .instr_ready_i (instr_ready_i),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          total = 0;
    int          bad   = 0;

    // reference model state
    ent_t        q[$];
    logic [31:0] exp_fetch;
    // bench memory state
    bit          busy;
    bit          stale;
    int          cnt;
    logic [31:0] mem_pc;
    logic [31:0] mem_data;
    logic [31:0] key;
    // per-cycle stimulus knobs
    bit          gnt_en;
    bit          ready;
    bit          redir;
    logic [31:0] redir_pc;
    int          lat_cfg;

    // Drive one cycle of stimulus (called at a falling edge), advance the
    // model across the next rising edge, return at the following falling edge.
    task automatic tick();
        bit   g;
        bit   rv;
        ent_t e;
        rv = busy && (cnt == 0);
        g  = imem_req_o && gnt_en && !busy;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_data : $urandom;
        redirect_i    = redir;
        redirect_pc_i = redir ? redir_pc : $urandom;
        instr_ready_i = ready;
        if (redir) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ready) void'(q.pop_front());
            if (rv && !stale) begin
                e.pc  = mem_pc;
                e.ins = mem_data;
                q.push_back(e);
            end
        end
        if (g) begin
            busy     = 1'b1;
            stale    = redir;
            cnt      = lat_cfg;
            mem_pc   = exp_fetch;
            mem_data = imem_addr_o ^ key;
        end else if (busy) begin
            if (rv) begin
                busy = 1'b0;
            end else begin
                cnt = cnt - 1;
                if (redir) stale = 1'b1;
            end
        end
        if (redir)  exp_fetch = redir_pc;
        else if (g) exp_fetch = exp_fetch + 32'd4;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
        q.delete();
        exp_fetch = RESET_PC;
        busy = 1'b0; stale = 1'b0; cnt = 0;
        gnt_en = 1'b1; ready = 1'b0; redir = 1'b0; lat_cfg = 0;
        key = $urandom;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        exp_fetch = RESET_PC; busy = 1'b0; stale = 1'b0; cnt = 0;
        gnt_en = 1'b1; ready = 1'b0; redir = 1'b0; lat_cfg = 0; key = 32'h0;
        @(negedge clk_i);
        total++;
        if ({imem_req_o, instr_valid_o, count_o, instr_o, pc_o} !== '0) begin
            bad++; $display("FAIL reset_outputs got req=%0d valid=%0d count=%0d instr=%h pc=%h want all 0",
                            imem_req_o, instr_valid_o, count_o, instr_o, pc_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        total++;
        if (imem_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle_req got=%0d want=0", imem_req_o);
        end
        tick();
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            bad++; $display("FAIL reset_first_req got req=%0d addr=%h want req=1 addr=%h",
                            imem_req_o, imem_addr_o, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        int nreq = 0;
        int npop = 0;
        int last = -1;
        do_reset();
        key = 32'h0; ready = 1'b1; lat_cfg = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (imem_req_o && nreq < 3) begin
                total++;
                if (imem_addr_o !== RESET_PC + 32'(4 * nreq)) begin
                    bad++; $display("FAIL zw_req_addr got=%h want=%h", imem_addr_o, RESET_PC + 32'(4 * nreq));
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 2) begin
                        bad++; $display("FAIL zw_req_spacing got=%0d want=2", cyc - last);
                    end
                end
                last = cyc;
                nreq++;
            end
            if (instr_valid_o && npop < 3) begin
                total++;
                if (pc_o !== 32'(4 * npop) || instr_o !== 32'(4 * npop) || pc_plus4_o !== 32'(4 * npop + 4)) begin
                    bad++; $display("FAIL zw_head got pc=%h instr=%h pc4=%h want pc=%h instr=%h pc4=%h",
                                    pc_o, instr_o, pc_plus4_o, 32'(4 * npop), 32'(4 * npop), 32'(4 * npop + 4));
                end
                npop++;
            end
            tick();
        end
        total++;
        if (nreq < 3 || npop < 3) begin
            bad++; $display("FAIL zw_progress got req=%0d pop=%0d want >=3 each", nreq, npop);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        ready = 1'b0; lat_cfg = 0;
        for (int g = 0; g < 60 && count_o != CW'(DEPTH); g++) tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (imem_req_o !== 1'b0 || count_o !== CW'(DEPTH)) begin
                bad++; $display("FAIL bp_full got req=%0d count=%0d want req=0 count=%0d", imem_req_o, count_o, DEPTH);
            end
            tick();
        end
        total++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== key) begin
            bad++; $display("FAIL bp_head got valid=%0d pc=%h instr=%h want 1 0 %h", instr_valid_o, pc_o, instr_o, key);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10 || count_o !== CW'(DEPTH - 1)) begin
            bad++; $display("FAIL bp_reissue got req=%0d addr=%h count=%0d want 1 10 %0d",
                            imem_req_o, imem_addr_o, count_o, DEPTH - 1);
        end
        ready = 1'b1;
        exp_pc = 32'h4;
        for (int g = 0; g < 60 && exp_pc <= 32'h14; g++) begin
            if (instr_valid_o) begin
                total++;
                if (pc_o !== exp_pc || instr_o !== (exp_pc ^ key)) begin
                    bad++; $display("FAIL bp_order got pc=%h instr=%h want pc=%h instr=%h", pc_o, instr_o, exp_pc, exp_pc ^ key);
                end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        total++;
        if (exp_pc !== 32'h18) begin
            bad++; $display("FAIL bp_drain got next_pc=%h want 00000018", exp_pc);
        end
    endtask

    task automatic test_gnt_delay();
        do_reset();
        gnt_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
                bad++; $display("FAIL gd_hold got req=%0d addr=%h want 1 %h", imem_req_o, imem_addr_o, RESET_PC);
            end
            if (i == 3) gnt_en = 1'b1;
            tick();
        end
        total++;
        if (imem_req_o !== 1'b0) begin
            bad++; $display("FAIL gd_after_gnt got req=%0d want 0", imem_req_o);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        do_reset();
        lat_cfg = 2;
        tick();
        tick();
        redir = 1'b1; redir_pc = 32'h40;
        tick();
        redir = 1'b0;
        tick();
        tick();
        total++;
        if (count_o !== '0 || instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) begin
            bad++; $display("FAIL rw_after_drop got count=%0d valid=%0d req=%0d addr=%h want 0 0 1 40",
                            count_o, instr_valid_o, imem_req_o, imem_addr_o);
        end
        lat_cfg = 0; ready = 1'b1;
        for (int g = 0; g < 20 && !found; g++) begin
            if (instr_valid_o) begin
                found = 1'b1;
                total++;
                if (pc_o !== 32'h40 || instr_o !== (32'h40 ^ key) || pc_plus4_o !== 32'h44) begin
                    bad++; $display("FAIL rw_first got pc=%h instr=%h pc4=%h want 40 %h 44", pc_o, instr_o, pc_plus4_o, 32'h40 ^ key);
                end
            end else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL rw_timeout got no valid want valid"); end
    endtask

    task automatic test_redirect_coincident();
        logic [31:0] tgt;
        bit found;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            lat_cfg = 0;
            tgt = (mode == 0) ? 32'h80 : 32'hC0;
            tick();
            if (mode == 1) tick();
            redir = 1'b1; redir_pc = tgt;
            tick();
            redir = 1'b0;
            if (mode == 0) tick();
            total++;
            if (count_o !== '0 || imem_req_o !== 1'b1 || imem_addr_o !== tgt) begin
                bad++; $display("FAIL rc%0d_state got count=%0d req=%0d addr=%h want 0 1 %h",
                                mode, count_o, imem_req_o, imem_addr_o, tgt);
            end
            ready = 1'b1;
            found = 1'b0;
            for (int g = 0; g < 20 && !found; g++) begin
                if (instr_valid_o) begin
                    found = 1'b1;
                    total++;
                    if (pc_o !== tgt || instr_o !== (tgt ^ key)) begin
                        bad++; $display("FAIL rc%0d_first got pc=%h instr=%h want %h %h", mode, pc_o, instr_o, tgt, tgt ^ key);
                    end
                end else tick();
            end
            total++;
            if (!found) begin bad++; $display("FAIL rc%0d_timeout got no valid want valid", mode); end
        end
        do_reset();
        for (int g = 0; g < 40 && count_o < CW'(2); g++) tick();
        ready = 1'b1; redir = 1'b1; redir_pc = 32'h100;
        tick();
        ready = 1'b0; redir = 1'b0;
        total++;
        if (count_o !== '0 || instr_valid_o !== 1'b0) begin
            bad++; $display("FAIL rc_pop_flush got count=%0d valid=%0d want 0 0", count_o, instr_valid_o);
        end
    endtask

    task automatic test_pc_wrap();
        int seen = 0;
        do_reset();
        gnt_en = 1'b0;
        tick();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        redir = 1'b0;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req got req=%0d addr=%h want 1 fffffffc", imem_req_o, imem_addr_o);
        end
        gnt_en = 1'b1; ready = 1'b1;
        for (int g = 0; g < 30 && seen < 2; g++) begin
            if (instr_valid_o) begin
                total++;
                if (pc_o !== 32'hFFFF_FFFC + 32'(4 * seen) || pc_plus4_o !== 32'(4 * seen)) begin
                    bad++; $display("FAIL wrap_head got pc=%h pc4=%h want %h %h",
                                    pc_o, pc_plus4_o, 32'hFFFF_FFFC + 32'(4 * seen), 32'(4 * seen));
                end
                seen++;
            end
            tick();
        end
        total++;
        if (seen != 2) begin bad++; $display("FAIL wrap_timeout got %0d heads want 2", seen); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        lat_cfg = 0;
        tick();
        tick();
        tick();
        lat_cfg = 3;
        tick();
        rst_i = 1'b0;
        #1;
        total++;
        if ({imem_req_o, instr_valid_o, count_o, instr_o, pc_o} !== '0) begin
            bad++; $display("FAIL rm_outputs got req=%0d valid=%0d count=%0d instr=%h pc=%h want all 0",
                            imem_req_o, instr_valid_o, count_o, instr_o, pc_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        q.delete();
        exp_fetch = RESET_PC;
        stale = 1'b1;
        key = key ^ 32'h5A5A_0001;
        lat_cfg = 0; ready = 1'b1;
        for (int g = 0; g < 30 && !found; g++) begin
            if (instr_valid_o) begin
                found = 1'b1;
                total++;
                if (pc_o !== RESET_PC || instr_o !== (RESET_PC ^ key) || count_o !== CW'(1)) begin
                    bad++; $display("FAIL rm_restart got pc=%h instr=%h count=%0d want %h %h 1",
                                    pc_o, instr_o, count_o, RESET_PC, RESET_PC ^ key);
                end
            end else tick();
        end
        total++;
        if (!found) begin bad++; $display("FAIL rm_timeout got no valid want valid"); end
    endtask

    task automatic test_random();
        bit          p_ok = 1'b0;
        bit          p_req;
        logic [31:0] p_addr;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            total++;
            if (count_o !== CW'(q.size()) || instr_valid_o !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_count cyc=%0d got count=%0d valid=%0d want %0d", cyc, count_o, instr_valid_o, q.size());
            end
            total++;
            if (q.size() != 0) begin
                if (pc_o !== q[0].pc || instr_o !== q[0].ins || pc_plus4_o !== q[0].pc + 32'd4) begin
                    bad++; $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h pc4=%h want %h %h %h",
                                    cyc, pc_o, instr_o, pc_plus4_o, q[0].pc, q[0].ins, q[0].pc + 32'd4);
                end
            end else if (pc_o !== 32'h0 || instr_o !== 32'h0) begin
                bad++; $display("FAIL rnd_empty cyc=%0d got pc=%h instr=%h want 0 0", cyc, pc_o, instr_o);
            end
            total++;
            if (imem_req_o === 1'b1 && imem_addr_o !== exp_fetch) begin
                bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, imem_addr_o, exp_fetch);
            end
            total++;
            if ((busy || q.size() == DEPTH) && imem_req_o !== 1'b0) begin
                bad++; $display("FAIL rnd_req_gate cyc=%0d got req=%0d want 0 (busy=%0d size=%0d)", cyc, imem_req_o, busy, q.size());
            end
            if (p_ok && p_req && !imem_gnt_i && !redirect_i) begin
                total++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== p_addr) begin
                    bad++; $display("FAIL rnd_hold cyc=%0d got req=%0d addr=%h want 1 %h", cyc, imem_req_o, imem_addr_o, p_addr);
                end
            end
            p_ok   = 1'b1;
            p_req  = imem_req_o;
            p_addr = imem_addr_o;
            gnt_en  = ($urandom % 4) != 0;
            ready   = ($urandom % 3) != 0;
            lat_cfg = $urandom % 4;
            redir   = ($urandom % 25) == 0;
            case ($urandom % 6)
                0:       redir_pc = 32'hFFFF_FFF8;
                1:       redir_pc = 32'hFFFF_FFFC;
                default: redir_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_gnt_delay();
        test_redirect_wait();
        test_redirect_coincident();
        test_pc_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
